mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Multicycle MIPS main controller. Sequences fetch/decode/execute/memory/writeback
//  over the shared ALU, register file and a single unified memory port.
//  Consumes the op/funct fields from the instruction-parser stage (driven from IR).
//  Drives all datapath selects and enables. Keeps cycle and retired-instruction counters.
// PARAMETERS
//  CNT_W        32   width of cycle_count and instr_count (both wrap modulo 2^CNT_W)
//  MEM_TIMEOUT  255  max wait cycles for mem_ready before abort (1..2^8-1)
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  op             in   6      opcode field of IR (valid from DECODE on)
//  funct          in   6      funct field of IR (valid from DECODE on)
//  zero           in   1      ALU zero flag
//  mem_ready      in   1      memory completes access this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if zero
//  iord           out  1      0: mem addr=PC, 1: mem addr=ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  ir_write       out  1      latch IR
//  reg_dst        out  1      1: write reg=rd, 0: rt
//  mem_to_reg     out  1      1: writeback from MDR
//  reg_write      out  1      register-file write enable
//  alu_src_a      out  1      0: PC, 1: A
//  alu_src_b      out  2      00: B, 01: 4, 10: sext immi, 11: sext immi<<2
//  alu_ctrl       out  4      0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT
//  pc_source      out  2      00: ALU, 01: ALUOut, 10: {PC[31:28],immj,2'b00}
//  illegal_op     out  1      1-cycle pulse: unsupported op/funct, or mem timeout
//  instr_retired  out  1      1-cycle pulse on final state of each instruction
//  state          out  4      current state encoding (debug)
//  cycle_count    out  CNT_W  cycles since reset
//  instr_count    out  CNT_W  retired instructions since reset
// BEHAVIOUR
//  - Reset: state=FETCH(0); counters=0; wait counter=0; all outputs 0 during reset=1.
//  - Moore outputs decoded from state, except handshake gating noted below.
//  - States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5,
//    R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11.
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD. Holds until
//    mem_ready. ir_write and pc_write are asserted only in the cycle mem_ready=1.
//    Then go to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target).
//    op 000000 -> R_EXEC; 100011 lw / 101011 sw -> MEM_ADDR; 000100 beq -> BRANCH;
//    000010 j -> JUMP; 001000 addi -> I_EXEC.
//    Other op, or R-type with funct not in {100000,100010,100100,100101,101010}:
//    illegal_op=1 and go to FETCH; nothing retired.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next: MEM_RD for lw, MEM_WR for sw.
//  - MEM_RD / MEM_WR: iord=1 with mem_read or mem_write; hold until mem_ready.
//    MEM_RD -> MEM_WB. MEM_WR -> FETCH (retires).
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 (retires).
//  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct. R_WB: reg_write=1, reg_dst=1 (retires).
//  - I_EXEC: alu_src_a=1, alu_src_b=10, ADD. I_WB: reg_write=1, reg_dst=0 (retires).
//  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01 (retires).
//  - JUMP: pc_write=1, pc_source=10 (retires).
//  - All retiring states return to FETCH and pulse instr_retired; instr_count += 1 same edge.
//  - Latency with mem_ready held at 1: beq/j 3, R/addi/sw 4, lw 5 cycles.
//  - Memory wait: wait counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each
//    cycle mem_ready=0. Reaching MEM_TIMEOUT: illegal_op pulse, go to FETCH, no retire,
//    no ir_write/pc_write/reg_write.
//  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
//  - cycle_count increments every non-reset cycle. Both counters wrap to 0.
//  - Reset mid-instruction: abort immediately, no partial write enables asserted.
// TESTING
//  1. reset 3 cycles, mem_ready=1, op=000000/funct=100000 -> states 0,1,6,7,0;
//     reg_write@R_WB; instr_count=1.
//  2. lw with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; mem_to_reg=1 in MEM_WB only.
//  3. beq zero=1 -> pc_write_cond=1, pc_source=01 in BRANCH; j -> pc_source=10, 3 cycles.
//  4. op=111111, and op=0/funct=000001 -> illegal_op pulse in DECODE, next state FETCH,
//     instr_count unchanged.
//  5. mem_ready=0 held in FETCH for MEM_TIMEOUT cycles -> illegal_op, ir_write never 1.
//  6. assert reset during MEM_WR -> all outputs 0 next cycle, state=FETCH, counters=0;
//     CNT_W=4 -> counters wrap 15->0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory port, with a bounded memory wait and
// cycle / retired-instruction counters.
module mips_multicycle_control #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             instr_retired,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       wait_q;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ins_q;
    logic             mem_state;
    logic             timeout;
    logic             legal_r;

    // The zero flag gates pc_write_cond in the datapath, not in this controller.
    logic unused_zero;
    assign unused_zero = zero;

    assign mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout   = mem_state && !mem_ready && (wait_q == 8'(MEM_TIMEOUT - 1));
    assign legal_r   = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset forces every visible output to zero, including debug state and counters.
    assign state       = reset ? 4'd0 : state_q;
    assign cycle_count = reset ? '0 : cyc_q;
    assign instr_count = reset ? '0 : ins_q;

    // State register and memory-wait counter (cleared on any state entry or abort).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || timeout)
                wait_q <= '0;
            else if (mem_state && !mem_ready)
                wait_q <= wait_q + 8'd1;
        end
    end

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (instr_retired)
                ins_q <= ins_q + CNT_W'(1);
        end
    end

    // Next-state and Moore output decode; fetch/memory strobes gated by mem_ready.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ctrl      = ALU_AND;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        instr_retired = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout) begin
                    illegal_op = 1'b1;
                    state_d    = FETCH;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (op)
                    OP_RTYPE: begin
                        if (legal_r) begin
                            state_d = R_EXEC;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = FETCH;
                        end
                    end
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = I_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (op == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = MEM_WB;
                end else if (timeout) begin
                    illegal_op = 1'b1;
                    state_d    = FETCH;
                end
            end
            MEM_WB: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = FETCH;
                end else if (timeout) begin
                    illegal_op = 1'b1;
                    state_d    = FETCH;
                end
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
                state_d = R_WB;
            end
            R_WB: begin
                reg_write     = 1'b1;
                reg_dst       = 1'b1;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctrl      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write      = 1'b1;
                pc_source     = 2'b10;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = I_WB;
            end
            I_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (reset) begin
            state_d       = FETCH;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_ctrl      = 4'b0000;
            pc_source     = 2'b00;
            illegal_op    = 1'b0;
            instr_retired = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: builds the expected per-cycle
// state/control trace of each instruction from its op, funct and memory wait counts.
module tb_mips_multicycle_control;

    localparam int CNT_W = 4;
    localparam int T     = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_ctrl;
    logic [1:0]       pc_source;
    logic             illegal_op, instr_retired;
    logic [3:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    mips_multicycle_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_source(pc_source), .illegal_op(illegal_op), .instr_retired(instr_retired),
        .state(state), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [19:0] dut_v;
    assign dut_v = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source,
                    illegal_op, instr_retired};

    int checks = 0;
    int errors = 0;
    int m_cyc  = 0;
    int m_ins  = 0;

    int          q_st[$];
    bit          q_rdy[$];
    logic [19:0] q_v[$];

    logic [5:0] r_functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] r_alu    [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    // Expected control vector for one cycle, straight from the per-state output table.
    function automatic logic [19:0] outv(int st, bit rdy, logic [5:0] fn, bit ill, bit ret);
        logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [3:0] ac = 0;
        case (st)
            0:  begin mr = 1; sb = 2'b01; ac = 4'b0010; if (rdy) begin irw = 1; pw = 1; end end
            1:  begin sb = 2'b11; ac = 4'b0010; end
            2:  begin sa = 1; sb = 2'b10; ac = 4'b0010; end
            3:  begin io = 1; mr = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; for (int i = 0; i < 5; i++) if (r_functs[i] == fn) ac = r_alu[i]; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ac = 4'b0110; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; ac = 4'b0010; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, rd, m2r, rw, sa, sb, ac, ps, ill, ret};
    endfunction

    task automatic push(int st, bit rdy, logic [5:0] fn, bit ill, bit ret);
        q_st.push_back(st);
        q_rdy.push_back(rdy);
        q_v.push_back(outv(st, rdy, fn, ill, ret));
    endtask

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expected trace of one instruction: wf/wm are not-ready cycles in fetch/memory.
    task automatic build(logic [5:0] o, logic [5:0] fn, int wf, int wm);
        bit r_ok = 0;
        int mst;
        foreach (r_functs[i]) if (r_functs[i] == fn) r_ok = 1;
        if (wf >= T) begin
            for (int i = 0; i < T; i++) push(0, 0, fn, i == T - 1, 0);
            return;
        end
        for (int i = 0; i < wf; i++) push(0, 0, fn, 0, 0);
        push(0, 1, fn, 0, 0);
        case (o)
            6'd0: begin
                if (r_ok) begin
                    push(1, rnd(), fn, 0, 0); push(6, rnd(), fn, 0, 0); push(7, rnd(), fn, 0, 1);
                end else begin
                    push(1, rnd(), fn, 1, 0);
                end
            end
            6'd35, 6'd43: begin
                push(1, rnd(), fn, 0, 0);
                push(2, rnd(), fn, 0, 0);
                mst = (o == 6'd35) ? 3 : 5;
                if (wm >= T) begin
                    for (int i = 0; i < T; i++) push(mst, 0, fn, i == T - 1, 0);
                end else begin
                    for (int i = 0; i < wm; i++) push(mst, 0, fn, 0, 0);
                    push(mst, 1, fn, 0, o == 6'd43);
                    if (o == 6'd35) push(4, rnd(), fn, 0, 1);
                end
            end
            6'd4: begin push(1, rnd(), fn, 0, 0); push(8, rnd(), fn, 0, 1); end
            6'd2: begin push(1, rnd(), fn, 0, 0); push(9, rnd(), fn, 0, 1); end
            6'd8: begin
                push(1, rnd(), fn, 0, 0); push(10, rnd(), fn, 0, 0); push(11, rnd(), fn, 0, 1);
            end
            default: push(1, rnd(), fn, 1, 0);
        endcase
    endtask

    // Plays n queued cycles (all if n < 0); each iteration starts and ends at a negedge.
    task automatic run_seq(int n);
        int done = 0;
        int st;
        logic [19:0] v;
        while (q_st.size() > 0 && (n < 0 || done < n)) begin
            st = q_st.pop_front();
            mem_ready = q_rdy.pop_front();
            v = q_v.pop_front();
            zero = rnd();
            #1;
            checks++;
            if ({state, dut_v, cycle_count, instr_count} !==
                {4'(st), v, CNT_W'(m_cyc), CNT_W'(m_ins)}) begin
                errors++;
                $display("FAIL cycle_trace op=%b fn=%b got st=%0d v=%h cc=%0d ic=%0d exp st=%0d v=%h cc=%0d ic=%0d",
                         op, funct, state, dut_v, cycle_count, instr_count,
                         st, v, CNT_W'(m_cyc), CNT_W'(m_ins));
            end
            @(posedge clk);
            m_cyc++;
            if (v[0]) m_ins++;
            @(negedge clk);
            done++;
        end
    endtask

    task automatic do_instr(logic [5:0] o, logic [5:0] fn, int wf, int wm);
        op = o;
        funct = fn;
        build(o, fn, wf, wm);
        run_seq(-1);
    endtask

    task automatic test_reset();
        reset = 1; mem_ready = 1; op = 6'd0; funct = 6'b100000; zero = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({state, dut_v, cycle_count, instr_count} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got st=%0d v=%h cc=%0d ic=%0d exp all zero",
                         state, dut_v, cycle_count, instr_count);
            end
            @(negedge clk);
        end
        reset = 0;
        m_cyc = 0;
        m_ins = 0;
    endtask

    task automatic test_directed();
        do_instr(6'd0, 6'b100000, 0, 0);      // add: 0,1,6,7
        do_instr(6'd35, 6'd0, 0, 2);          // lw with two stalled cycles: 7 cycles
        do_instr(6'd4, 6'd0, 0, 0);           // beq
        do_instr(6'd2, 6'd0, 0, 0);           // j
        do_instr(6'd43, 6'd0, 1, 1);          // sw with stalls
        do_instr(6'd8, 6'd0, 0, 0);           // addi
        do_instr(6'b111111, 6'd0, 0, 0);      // illegal op
        do_instr(6'd0, 6'b000001, 0, 0);      // illegal funct
        for (int i = 1; i < 5; i++) do_instr(6'd0, r_functs[i], 0, 0);
    endtask

    task automatic test_timeout();
        do_instr(6'd0, 6'b100000, T, 0);      // fetch never ready
        do_instr(6'd43, 6'd0, 0, T);          // store never ready
        do_instr(6'd35, 6'd0, 2, T);          // load never ready
        do_instr(6'd35, 6'd0, 0, T - 1);      // load ready on last allowed cycle
        do_instr(6'd0, 6'b100000, T - 1, 0);  // fetch ready on last allowed cycle
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 17; i++) do_instr(6'd0, 6'b100000, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd0, 6'd0};
        logic [5:0] o, fn;
        int wf, wm;
        for (int i = 0; i < 80; i++) begin
            o  = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            fn = ($urandom_range(0, 3) != 0) ? r_functs[$urandom_range(0, 4)] : 6'($urandom);
            wf = ($urandom_range(0, 11) == 0) ? T : $urandom_range(0, 2);
            wm = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, 3);
            do_instr(o, fn, wf, wm);
        end
    endtask

    task automatic test_reset_mid();
        op = 6'd43;
        funct = 6'd0;
        build(6'd43, 6'd0, 0, 3);
        run_seq(4);                           // now in second MEM_WR cycle
        q_st.delete(); q_rdy.delete(); q_v.delete();
        reset = 1;
        mem_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({state, dut_v, cycle_count, instr_count} !== '0) begin
                errors++;
                $display("FAIL reset_mid_outputs got st=%0d v=%h cc=%0d ic=%0d exp all zero",
                         state, dut_v, cycle_count, instr_count);
            end
            @(negedge clk);
        end
        reset = 0;
        m_cyc = 0;
        m_ins = 0;
        do_instr(6'd2, 6'd0, 0, 0);
        do_instr(6'd0, 6'b101010, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
